riscv_test_monitor: RTL

//  Synthesizable, parametrised pass/fail/timeout monitor for riscv-tests runs on Core.

---
 rtl/riscv_test_monitor.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor
//
// Pass/fail/timeout monitor for riscv-tests runs. It sits beside the core and
// watches three things: the executing PC, the gp (x3) register and
// data-memory stores. From these it decides the outcome of the run:
//   - end-PC match : at PASS_PC, gp==1 means PASS, anything else means FAIL
//   - tohost store : a non-zero store to TOHOST_ADDR; 1 means PASS, else FAIL
//   - watchdog     : TIMEOUT cycles in RUN with no decision means TIMEOUT
// Terminal results are sticky. Only rst or clear leaves them, so a host or LED
// readout can sample them at leisure.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous, active-high reset
//   en         in   1        start monitoring (level, sampled in IDLE only)
//   clear      in   1        synchronous return to IDLE, clears all results
//   pc_valid   in   1        pc holds a valid executing instruction
//   pc         in   XLEN     current PC
//   gp         in   XLEN     current x3 value
//   mem_we     in   1        data-memory store strobe
//   mem_addr   in   XLEN     store address
//   mem_wdata  in   XLEN     store data
//   done       out  1        high in PASS, FAIL or TIMEOUT
//   passed     out  1        high in PASS
//   failed     out  1        high in FAIL
//   timed_out  out  1        high in TIMEOUT
//   fail_code  out  XLEN-1   failing test number (code >> 1), 0 unless FAIL
//   result_vld out  1        one-cycle pulse on the first terminal cycle
//   cycles     out  CNT_W    cycles spent in RUN, saturating
//
// Interface semantics: there is no valid/ready handshake here. pc_valid and
// mem_we are plain qualifiers for the same-cycle pc and mem_* buses; there is
// no back-pressure, and every qualified cycle is observed. result_vld acts as
// a valid-only strobe that needs no acknowledge; the level outputs stay put.
//
// TIMEOUT - 1 must be representable in CNT_W bits.

module riscv_test_monitor #(
  parameter int              XLEN        = 32,
  parameter int              MODE        = 2,
  parameter logic [XLEN-1:0] PASS_PC     = 32'h0000_0044,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int              TIMEOUT     = 5000,
  parameter int              CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             pc_valid,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  gp,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             done,
  output logic             passed,
  output logic             failed,
  output logic             timed_out,
  output logic [XLEN-2:0]  fail_code,
  output logic             result_vld,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3,
    S_TMO  = 3'd4
  } state_t;

  localparam logic [XLEN-1:0]  CODE_PASS = XLEN'(1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic             USE_PC    = (MODE != 1);
  localparam logic             USE_TH    = (MODE != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [XLEN-2:0]  fail_code_q, fail_code_d;
  logic             vld_q, vld_d;

  // Per-cycle event detection; only meaningful while in RUN.
  logic             pc_ev;
  logic             th_ev;
  logic             to_ev;
  logic [CNT_W-1:0] cycles_inc;

  always_comb begin
    pc_ev = USE_PC && pc_valid && (pc == PASS_PC);
    // A tohost store of zero carries no result and is ignored.
    th_ev = USE_TH && mem_we && (mem_addr == TOHOST_ADDR) && (mem_wdata != '0);
    to_ev = (cycles_q == TMO_LAST);
    // Saturate at all-ones rather than wrap.
    cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
  end

  // Next-state logic. Priority: clear > tohost > end-PC > watchdog.
  always_comb begin
    state_d     = state_q;
    cycles_d    = cycles_q;
    fail_code_d = fail_code_q;
    vld_d       = 1'b0;

    if (clear) begin
      state_d     = S_IDLE;
      cycles_d    = '0;
      fail_code_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en) begin
            state_d  = S_RUN;
            cycles_d = '0;
          end
        end

        S_RUN: begin
          // The deciding cycle is still counted, so a terminal cycles value
          // equals the event cycle index + 1; afterwards it stays frozen.
          cycles_d = cycles_inc;
          if (th_ev) begin
            vld_d = 1'b1;
            if (mem_wdata == CODE_PASS) begin
              state_d = S_PASS;
            end else begin
              state_d     = S_FAIL;
              fail_code_d = mem_wdata[XLEN-1:1];
            end
          end else if (pc_ev) begin
            vld_d = 1'b1;
            if (gp == CODE_PASS) begin
              state_d = S_PASS;
            end else begin
              state_d     = S_FAIL;
              fail_code_d = gp[XLEN-1:1];
            end
          end else if (to_ev) begin
            vld_d   = 1'b1;
            state_d = S_TMO;
          end
        end

        // Terminal states are sticky; only clear or rst leaves them.
        S_PASS, S_FAIL, S_TMO: begin
          state_d = state_q;
        end

        default: begin
          state_d     = S_IDLE;
          cycles_d    = '0;
          fail_code_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cycles_q    <= '0;
      fail_code_q <= '0;
      vld_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycles_q    <= cycles_d;
      fail_code_q <= fail_code_d;
      vld_q       <= vld_d;
    end
  end

  // Level outputs are decoded straight from the state register.
  always_comb begin
    passed     = (state_q == S_PASS);
    failed     = (state_q == S_FAIL);
    timed_out  = (state_q == S_TMO);
    done       = passed || failed || timed_out;
    fail_code  = fail_code_q;
    result_vld = vld_q;
    cycles     = cycles_q;
  end

endmodule
